reg_bank_arbiter: RTL

REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

---
 rtl/reg_bank_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/reg_bank_arbiter.sv
// Two-requester register bank with a one-cycle grant FSM (IDLE -> GRANT_x -> IDLE).
// Define REG_BANK_ARB_RR_EN for round-robin tie-break; default build gives requester A fixed priority.
module reg_bank_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              busy,
    output logic [1:0]        state_dbg,
    output logic              last_grant_dbg
);

    localparam int NREG = 1 << ADDR_W;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_A = 2'd1;
    localparam logic [1:0] GRANT_B = 2'd2;

    localparam logic LG_A = 1'b0;
    localparam logic LG_B = 1'b1;

    // Handshake: a requester holds req/we/addr/wdata until its one-cycle ack;
    // req still high in the cycle after ack counts as a fresh request.
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              last_grant;
    logic [DATA_W-1:0] regs [NREG];

    always_comb begin
        state_nxt = IDLE;
        if (state == IDLE) begin
            if (req_a && req_b) begin
`ifdef REG_BANK_ARB_RR_EN
                state_nxt = (last_grant == LG_A) ? GRANT_B : GRANT_A;
`else
                state_nxt = GRANT_A;
`endif
            end else if (req_a) begin
                state_nxt = GRANT_A;
            end else if (req_b) begin
                state_nxt = GRANT_B;
            end
        end
    end

    // Read data is captured on the edge entering the grant so it is valid alongside ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= LG_B;
            rdata_a    <= '0;
            rdata_b    <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (state_nxt == GRANT_A) begin
                last_grant <= LG_A;
                if (!we_a) begin
                    rdata_a <= regs[addr_a];
                end
            end
            if (state_nxt == GRANT_B) begin
                last_grant <= LG_B;
                if (!we_b) begin
                    rdata_b <= regs[addr_b];
                end
            end
            if (state == GRANT_A && we_a) begin
                regs[addr_a] <= wdata_a;
            end
            if (state == GRANT_B && we_b) begin
                regs[addr_b] <= wdata_b;
            end
        end
    end

    assign ack_a          = (state == GRANT_A);
    assign ack_b          = (state == GRANT_B);
    assign busy           = (state != IDLE);
    assign state_dbg      = state;
    assign last_grant_dbg = last_grant;

endmodule
